// File: rtl/counters_pkg.sv
// Shared definitions for logic that consumes the free-running up-counter.
// Provides the default count width and the modular +1 used for sequence checks.
package counters_pkg;

  localparam int CNT_W_DEFAULT = 4;

  function automatic logic [31:0] inc_mod(input logic [31:0] value, input int unsigned width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (value + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/count_pwm_shadow.sv
// Duty shadow register with valid/ready load; the shadow becomes active only on a period wrap.
// Latency: accepted duty goes live at the next wrap; duty_ready stays low while a load is pending.
module count_pwm_shadow
  import counters_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [CNT_W:0] duty_in,
  input  logic           duty_valid,
  output logic           duty_ready,
  input  logic           wrap,
  output logic [CNT_W:0] active_duty_nxt
);

  localparam logic [CNT_W:0] DUTY_MAX = {1'b1, {CNT_W{1'b0}}};

  logic [CNT_W:0] shadow_q, shadow_d;
  logic [CNT_W:0] active_duty_q, active_duty_d;
  logic [CNT_W:0] duty_clamped;
  logic           pending_q, pending_d;

  always_comb begin
    duty_clamped  = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    active_duty_d = active_duty_q;
    if (wrap && pending_q) begin
      active_duty_d = shadow_q;
      pending_d     = 1'b0;
    end
    // A load can only be accepted while nothing is pending, so it never collides with the swap.
    if (duty_valid && !pending_q) begin
      shadow_d  = duty_clamped;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q      <= '0;
      active_duty_q <= '0;
      pending_q     <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      active_duty_q <= active_duty_d;
      pending_q     <= pending_d;
    end
  end

  assign duty_ready      = ~pending_q;
  assign active_duty_nxt = active_duty_d;

endmodule

// File: rtl/count_pwm_gen.sv
// PWM, period tick/count and sequence-error monitor driven by an external up-counter value.
// Latency: 1 clk from count to all outputs; duty loads are backpressured via duty_ready.
module count_pwm_gen
  import counters_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CNT_W-1:0]    count,
  input  logic [CNT_W:0]      duty_in,
  input  logic                duty_valid,
  output logic                duty_ready,
  input  logic                err_clr,
  output logic                pwm,
  output logic                period_tick,
  output logic [PERIOD_W-1:0] period_cnt,
  output logic                seq_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    prev_cnt_q, prev_cnt_d;
  logic                prev_vld_q, prev_vld_d;
  logic                pwm_q, pwm_d;
  logic                tick_q, tick_d;
  logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
  logic                seq_err_q, seq_err_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic [CNT_W:0]      active_duty_nxt;
  logic                wrap;
  logic                seq_set;

  count_pwm_shadow #(.CNT_W(CNT_W)) u_shadow (
    .clk             (clk),
    .reset           (reset),
    .duty_in         (duty_in),
    .duty_valid      (duty_valid),
    .duty_ready      (duty_ready),
    .wrap            (wrap),
    .active_duty_nxt (active_duty_nxt)
  );

  always_comb begin
    cnt_inc      = CNT_W'(inc_mod(32'(prev_cnt_q), CNT_W));
    wrap         = prev_vld_q && (prev_cnt_q == CNT_MAX) && (count == '0);
    // A jump to zero is an upstream counter reset, not a sequence fault.
    seq_set      = prev_vld_q && (count != cnt_inc) && (count != '0);
    prev_cnt_d   = count;
    prev_vld_d   = 1'b1;
    pwm_d        = ({1'b0, count} < active_duty_nxt);
    tick_d       = wrap;
    period_cnt_d = period_cnt_q + PERIOD_W'(wrap);
    seq_err_d    = seq_err_q;
    if (err_clr) seq_err_d = 1'b0;
    if (seq_set) seq_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_cnt_q   <= '0;
      prev_vld_q   <= 1'b0;
      pwm_q        <= 1'b0;
      tick_q       <= 1'b0;
      period_cnt_q <= '0;
      seq_err_q    <= 1'b0;
    end else begin
      prev_cnt_q   <= prev_cnt_d;
      prev_vld_q   <= prev_vld_d;
      pwm_q        <= pwm_d;
      tick_q       <= tick_d;
      period_cnt_q <= period_cnt_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign pwm         = pwm_q;
  assign period_tick = tick_q;
  assign period_cnt  = period_cnt_q;
  assign seq_err     = seq_err_q;

endmodule
